// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select codes,
// FSM state encoding and the shadow-pipe entry layout.
package pipe_hazard_pkg;

  localparam int SHADOW_RD_W = 5;
  localparam int FWD_SEL_W   = 2;

  // Operand source selects driven onto fwd_a / fwd_b
  localparam logic [FWD_SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_SEL_W-1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL1 = 2'd1,
    ST_STALL2 = 2'd2
  } hz_state_e;

  // What the hazard logic needs to remember about an in-flight instruction
  typedef struct packed {
    logic [SHADOW_RD_W-1:0] rd;
    logic                   rf_en;
    logic                   load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // An invalid ID slot enters the shadow pipe as a bubble
  function automatic shadow_entry_t make_entry(input logic                   valid,
                                               input logic [SHADOW_RD_W-1:0] rd,
                                               input logic                   rf_en,
                                               input logic                   load);
    shadow_entry_t e;
    e = SHADOW_BUBBLE;
    if (valid) begin
      e.rd    = rd;
      e.rf_en = rf_en;
      e.load  = load;
    end
    return e;
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage instruction description in, pipeline control and forwarding
// selects out. The pipeline datapath is the master, the hazard unit the slave.
interface pipeline_hazard_unit_if
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = SHADOW_RD_W,
  parameter int FWD_W      = FWD_SEL_W
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rf_enable;
  logic                  id_load_instr;
  logic                  id_branch_instr;
  logic                  id_branch_taken;

  logic                  pc_ld;
  logic                  npc_ld;
  logic                  ifid_ld;
  logic                  S;
  logic                  npc_src;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_rf_enable, id_load_instr, id_branch_instr, id_branch_taken,
    input  pc_ld, npc_ld, ifid_ld, S, npc_src, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_rf_enable, id_load_instr, id_branch_instr, id_branch_taken,
    output pc_ld, npc_ld, ifid_ld, S, npc_src, fwd_a, fwd_b
  );

endinterface

// File: rtl/pipeline_hazard_unit_shadow.sv
// Three-entry shadow of the EX/MEM/WB destination state. A stall turns the
// entry leaving ID into a bubble while older entries keep draining.
module hazard_shadow_pipe
  import pipe_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  shadow_entry_t id_ent,
  output shadow_entry_t ex_ent_p0,
  output shadow_entry_t mem_ent_p1,
  output shadow_entry_t wb_ent_p2
);

  // Advance the shadow pipe every cycle, inserting a bubble into EX on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ent_p0  <= SHADOW_BUBBLE;
      mem_ent_p1 <= SHADOW_BUBBLE;
      wb_ent_p2  <= SHADOW_BUBBLE;
    end else begin
      // ID -> EX
      ex_ent_p0  <= stall ? SHADOW_BUBBLE : id_ent;
      // EX -> MEM
      mem_ent_p1 <= ex_ent_p0;
      // MEM -> WB
      wb_ent_p2  <= mem_ent_p1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a five-stage pipeline with ID-resolved branches and one
// delay slot: operand forwarding selects, load-use and branch-operand stalls,
// and the bubble select S for the control mux.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall_cycles and
// branch_redirects counters.
module pipeline_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = SHADOW_RD_W,
  parameter int FWD_W      = FWD_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          branch_redirects
`endif
);

  shadow_entry_t    id_ent;
  shadow_entry_t    ex_ent_p0;
  shadow_entry_t    mem_ent_p1;
  shadow_entry_t    wb_ent_p2;

  logic             use_a;
  logic             use_b;
  logic             is_branch;
  logic             ex_a, mem_a, wb_a;
  logic             ex_b, mem_b, wb_b;
  logic             ex_hit;
  logic             mem_hit;
  logic             need1;
  logic             need2;
  logic             stall;
  logic             ld_en;
  logic             bubble;
  logic             redirect;
  logic [FWD_W-1:0] fwd_a_c;
  logic [FWD_W-1:0] fwd_b_c;

  hz_state_e        state;
  hz_state_e        state_nxt;

  // r0 is hard-wired zero, so it never creates a dependency
  function automatic logic stage_match(input shadow_entry_t         e,
                                       input logic                  used,
                                       input logic [REG_ADDR_W-1:0] src);
    return used && e.rf_en && (e.rd == src) && (src != '0);
  endfunction

  // Youngest producer wins
  function automatic logic [FWD_W-1:0] fwd_select(input logic ex_m,
                                                  input logic mem_m,
                                                  input logic wb_m);
    if (ex_m)  return FWD_EX;
    if (mem_m) return FWD_MEM;
    if (wb_m)  return FWD_WB;
    return FWD_RF;
  endfunction

  assign use_a     = hz.id_valid & hz.id_uses_rs;
  assign use_b     = hz.id_valid & hz.id_uses_rt;
  assign is_branch = hz.id_valid & hz.id_branch_instr;
  assign id_ent    = make_entry(hz.id_valid, hz.id_rd, hz.id_rf_enable, hz.id_load_instr);

  hazard_shadow_pipe u_shadow (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .id_ent     (id_ent),
    .ex_ent_p0  (ex_ent_p0),
    .mem_ent_p1 (mem_ent_p1),
    .wb_ent_p2  (wb_ent_p2)
  );

  assign ex_a  = stage_match(ex_ent_p0,  use_a, hz.id_rs);
  assign mem_a = stage_match(mem_ent_p1, use_a, hz.id_rs);
  assign wb_a  = stage_match(wb_ent_p2,  use_a, hz.id_rs);
  assign ex_b  = stage_match(ex_ent_p0,  use_b, hz.id_rt);
  assign mem_b = stage_match(mem_ent_p1, use_b, hz.id_rt);
  assign wb_b  = stage_match(wb_ent_p2,  use_b, hz.id_rt);

  // rs and rt hazards merge into one requirement; the longer one dominates
  assign ex_hit  = ex_a  | ex_b;
  assign mem_hit = mem_a | mem_b;
  assign need2   = is_branch & ex_ent_p0.load & ex_hit;
  assign need1   = (ex_ent_p0.load & ex_hit)
                 | (is_branch & ex_hit)
                 | (is_branch & mem_ent_p1.load & mem_hit);

  assign fwd_a_c = fwd_select(ex_a, mem_a, wb_a);
  assign fwd_b_c = fwd_select(ex_b, mem_b, wb_b);

  // Stall sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state and stall decision; STALL1 re-evaluates exactly like RUN
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      ST_RUN, ST_STALL1: begin
        stall = need1 | need2;
        if (need2)      state_nxt = ST_STALL2;
        else if (need1) state_nxt = ST_STALL1;
        else            state_nxt = ST_RUN;
      end
      ST_STALL2: begin
        stall     = 1'b1;
        state_nxt = ST_STALL1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Pipeline control outputs; reset overrides everything combinationally
  always_comb begin
    ld_en    = 1'b1;
    bubble   = 1'b0;
    redirect = 1'b0;
    if (reset) begin
      ld_en  = 1'b0;
      bubble = 1'b1;
    end else if (stall) begin
      ld_en  = 1'b0;
      bubble = 1'b1;
    end else begin
      redirect = is_branch & hz.id_branch_taken;
    end
  end

  assign hz.pc_ld   = ld_en;
  assign hz.npc_ld  = ld_en;
  assign hz.ifid_ld = ld_en;
  assign hz.S       = bubble;
  assign hz.npc_src = redirect;
  assign hz.fwd_a   = reset ? FWD_RF : fwd_a_c;
  assign hz.fwd_b   = reset ? FWD_RF : fwd_b_c;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters for stall cycles and taken redirects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles     <= '0;
      branch_redirects <= '0;
    end else begin
      if (bubble)   stall_cycles     <= sat_inc(stall_cycles);
      if (redirect) branch_redirects <= sat_inc(branch_redirects);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed hazard scenarios
// followed by randomized instruction streams, all compared against a
// reference model that tracks the last three issued instructions.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_ADDR_W(5), .FWD_W(2)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] branch_redirects;
`endif

  pipeline_hazard_unit #(.REG_ADDR_W(5), .FWD_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .branch_redirects (branch_redirects)
`endif
  );

  // Reference model: one record per instruction in EX, MEM, WB (index 0..2)
  typedef struct {
    int rd;
    bit wen;
    bit ld;
  } m_ent_t;

  m_ent_t m_pipe[3];
  int     m_forced;
  int     m_stalls;
  int     m_redirs;
  bit     last_stall;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] obs_ctl;  // {pc_ld, npc_ld, ifid_ld, S, npc_src}
  logic [1:0] obs_fa;
  logic [1:0] obs_fb;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{rd: 0, wen: 1'b0, ld: 1'b0};
    m_forced   = 0;
    m_stalls   = 0;
    m_redirs   = 0;
    last_stall = 1'b0;
  endfunction

  // Index of the youngest in-flight writer of src, or -1
  function automatic int youngest(input int src, input bit used);
    if (!used || src == 0) return -1;
    for (int i = 0; i < 3; i++)
      if (m_pipe[i].wen && m_pipe[i].rd == src) return i;
    return -1;
  endfunction

  // Stall cycles this operand needs given where its producer sits
  function automatic int stalls_for(input int idx, input bit branch);
    if (idx == 0) begin
      if (m_pipe[0].ld) return branch ? 2 : 1;
      return branch ? 1 : 0;
    end
    if (idx == 1 && branch && m_pipe[1].ld) return 1;
    return 0;
  endfunction

  // Present one ID instruction for a cycle, compare outputs, advance model.
  // Called shortly after a rising edge; returns shortly after the next one.
  task automatic issue(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int rd, input bit wen, input bit ld, input bit br, input bit tk);
    int ia, ib, need, n;
    bit stall, redir;
    logic [4:0] exp_ctl;
    bus.id_valid        = v;
    bus.id_rs           = rs[4:0];
    bus.id_rt           = rt[4:0];
    bus.id_uses_rs      = urs;
    bus.id_uses_rt      = urt;
    bus.id_rd           = rd[4:0];
    bus.id_rf_enable    = wen;
    bus.id_load_instr   = ld;
    bus.id_branch_instr = br;
    bus.id_branch_taken = tk;
    #3;
    ia   = youngest(rs, v && urs);
    ib   = youngest(rt, v && urt);
    need = stalls_for(ia, v && br);
    n    = stalls_for(ib, v && br);
    if (n > need) need = n;
    stall   = (m_forced > 0) || (need > 0);
    redir   = v && br && tk && !stall;
    exp_ctl = stall ? 5'b00010 : {4'b1110, redir};
    obs_ctl = {bus.pc_ld, bus.npc_ld, bus.ifid_ld, bus.S, bus.npc_src};
    obs_fa  = bus.fwd_a;
    obs_fb  = bus.fwd_b;
    check_val("ctl", {27'b0, obs_ctl}, {27'b0, exp_ctl});
    check_val("fwd_a", {30'b0, obs_fa}, ia + 1);
    check_val("fwd_b", {30'b0, obs_fb}, ib + 1);
    if (m_forced > 0)   m_forced--;
    else if (need == 2) m_forced = 1;
    if (stall) m_stalls++;
    if (redir) m_redirs++;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    if (stall || !v) m_pipe[0] = '{rd: 0, wen: 1'b0, ld: 1'b0};
    else             m_pipe[0] = '{rd: rd, wen: wen, ld: ld};
    last_stall = stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rs, rt, rd;
    bit v, urs, urt, wen, ld, br, tk;

    reset               = 1'b1;
    bus.id_valid        = 1'b0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.id_rd           = '0;
    bus.id_rf_enable    = 1'b0;
    bus.id_load_instr   = 1'b0;
    bus.id_branch_instr = 1'b0;
    bus.id_branch_taken = 1'b0;
    model_reset();
    #1;
    check_val("reset_ctl", {27'b0, bus.pc_ld, bus.npc_ld, bus.ifid_ld, bus.S, bus.npc_src}, 32'h2);
    check_val("reset_fwd", {28'b0, bus.fwd_a, bus.fwd_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // EX and MEM forwarding of an ALU result
    issue(1, 1, 0, 1, 0, 2, 1, 0, 0, 0);                 // addiu r2, r1
    issue(1, 2, 4, 1, 1, 3, 1, 0, 0, 0);                 // subu r3, r2, r4
    check_val("t1_fwd_ex", {30'b0, obs_fa}, 32'd1);
    check_val("t1_no_stall", {31'b0, obs_ctl[1]}, 32'd0);
    issue(1, 2, 0, 1, 0, 0, 0, 0, 0, 0);                 // reader of r2
    check_val("t1_fwd_mem", {30'b0, obs_fa}, 32'd2);

    // Load-use: one bubble, then memory forwarding
    issue(1, 1, 0, 1, 0, 5, 1, 1, 0, 0);                 // lbu r5
    issue(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);                 // subu r6, r5, r1
    check_val("t2_stall_S", {31'b0, obs_ctl[1]}, 32'd1);
    check_val("t2_stall_ld", {30'b0, obs_ctl[4], obs_ctl[2]}, 32'd0);
    issue(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    check_val("t2_fwd_mem", {30'b0, obs_fa}, 32'd2);
    check_val("t2_release", {31'b0, obs_ctl[1]}, 32'd0);

    // Load feeding a branch: two bubbles, redirect on the third cycle
    issue(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);                 // lbu r7
    issue(1, 7, 0, 1, 0, 0, 0, 0, 1, 1);                 // bgtz r7 (taken)
    check_val("t3_c1", {27'b0, obs_ctl}, 32'h02);
    issue(1, 7, 0, 1, 0, 0, 0, 0, 1, 1);
    check_val("t3_c2", {27'b0, obs_ctl}, 32'h02);
    issue(1, 7, 0, 1, 0, 0, 0, 0, 1, 1);
    check_val("t3_c3", {27'b0, obs_ctl}, 32'h1D);

    // r0 destination never forwards or stalls
    issue(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);                 // load to r0
    issue(1, 0, 0, 1, 1, 0, 0, 0, 1, 0);                 // branch reading r0, r0
    check_val("t4_fwd", {28'b0, obs_fa, obs_fb}, 32'd0);
    check_val("t4_no_stall", {31'b0, obs_ctl[1]}, 32'd0);

    // Three writers of r9: youngest wins
    repeat (3) issue(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    issue(1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
    check_val("t5_fwd_b", {30'b0, obs_fb}, 32'd1);

    // Reset while in STALL2
    issue(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);                 // lbu r7
    issue(1, 7, 0, 1, 0, 0, 0, 0, 1, 1);                 // bgtz r7 -> STALL2 next
    #2;
    check_val("t6_in_stall2", {31'b0, bus.S}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("t6_reset_ctl", {27'b0, bus.pc_ld, bus.npc_ld, bus.ifid_ld, bus.S, bus.npc_src}, 32'h2);
    check_val("t6_reset_fwd", {28'b0, bus.fwd_a, bus.fwd_b}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    check_val("t6_stall_cnt", stall_cycles, 32'd0);
    check_val("t6_redir_cnt", branch_redirects, 32'd0);
`endif
    issue(1, 7, 0, 1, 0, 0, 0, 0, 1, 1);
    check_val("t6_after_S", {31'b0, obs_ctl[1]}, 32'd0);
    check_val("t6_after_redir", {31'b0, obs_ctl[0]}, 32'd1);

    // Randomized stream; a stalled ID instruction is held as IF/ID would hold it
    rs = 0; rt = 0; rd = 0;
    v = 0; urs = 0; urt = 0; wen = 0; ld = 0; br = 0; tk = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        v   = ($urandom_range(0, 7) != 0);
        rs  = $urandom_range(0, 7);
        rt  = $urandom_range(0, 7);
        urs = $urandom_range(0, 3) != 0;
        urt = $urandom_range(0, 1) != 0;
        rd  = $urandom_range(0, 7);
        br  = ($urandom_range(0, 3) == 0);
        wen = !br && ($urandom_range(0, 9) < 7);
        ld  = wen && ($urandom_range(0, 2) == 0);
      end
      tk = $urandom_range(0, 1) != 0;
      issue(v, rs, rt, urs, urt, rd, wen, ld, br, tk);
    end

`ifdef HAZARD_PERF_CNT_EN
    check_val("stall_cnt", stall_cycles, m_stalls);
    check_val("redir_cnt", branch_redirects, m_redirs);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
